// File: rtl/mve_pkg.sv
// Shared opcodes and FSM state encoding for the register-move execution unit.
package mve_pkg;

  localparam logic [3:0] OPC_MOV = 4'b1011;
  localparam logic [3:0] OPC_MVI = 4'b1100;
  localparam logic [3:0] OPC_SWP = 4'b1101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_WR1,
    ST_WR2,
    ST_DONE
  } state_t;

  function automatic logic opc_legal(input logic [3:0] opc);
    return (opc == OPC_MOV) || (opc == OPC_MVI) || (opc == OPC_SWP);
  endfunction

endpackage

// File: rtl/mve_delay_ctr.sv
// Loadable stall down-counter; zero marks the cycle whose decrement empties it,
// so the caller leaves its wait state after exactly LAT cycles.
module mve_delay_ctr #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LAT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt <= CW'(1));

endmodule

// File: rtl/mve_unit.sv
// Register-move execution unit (MOV / MVI / SWP) driving an external register file.
// Define MVE_BACK2BACK_EN to let DONE accept a new start directly.
module mve_unit
  import mve_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 3,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    ctr1,
  input  logic [AW-1:0] radd1,
  input  logic [AW-1:0] radd2,
  input  logic [DW-1:0] imm,
  output logic [AW-1:0] rf_raddr_a,
  input  logic [DW-1:0] rf_rdata_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          busy,
  output logic          ctr2,
  output logic          err
);

`ifdef MVE_BACK2BACK_EN
  localparam logic DONE_BUSY = 1'b0;
`else
  localparam logic DONE_BUSY = 1'b1;
`endif

  state_t        state;
  logic [3:0]    opc;
  logic [AW-1:0] dst;
  logic [AW-1:0] src;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] src_val;
  logic [DW-1:0] dst_val;
  logic          accept;
  logic          ctr_zero;
  logic [DW-1:0] wr1_data;

  mve_delay_ctr #(.LAT(LAT)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == ST_LOAD),
    .dec  (state == ST_WAIT),
    .zero (ctr_zero)
  );

  always_comb begin
    accept = start && (state == ST_IDLE);
`ifdef MVE_BACK2BACK_EN
    if (start && (state == ST_DONE)) accept = 1'b1;
`endif
  end

  // With LAT=0 the first write is issued on the same edge as operand capture,
  // so the source value must bypass the holding register.
  always_comb begin
    wr1_data = (state == ST_LOAD) ? rf_rdata_a : src_val;
    if (opc == OPC_MVI) wr1_data = imm_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      opc        <= '0;
      dst        <= '0;
      src        <= '0;
      imm_q      <= '0;
      src_val    <= '0;
      dst_val    <= '0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      busy       <= 1'b0;
      ctr2       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      ctr2  <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (!opc_legal(opc)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            src_val <= rf_rdata_a;
            dst_val <= rf_rdata_b;
            if (LAT == 0) begin
              state    <= ST_WR1;
              rf_we    <= 1'b1;
              rf_waddr <= dst;
              rf_wdata <= wr1_data;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ctr_zero) begin
            state    <= ST_WR1;
            rf_we    <= 1'b1;
            rf_waddr <= dst;
            rf_wdata <= wr1_data;
          end
        end
        ST_WR1: begin
          if (opc == OPC_SWP) begin
            state    <= ST_WR2;
            rf_we    <= 1'b1;
            rf_waddr <= src;
            rf_wdata <= dst_val;
          end else begin
            state <= ST_DONE;
            ctr2  <= 1'b1;
            busy  <= DONE_BUSY;
          end
        end
        ST_WR2: begin
          state <= ST_DONE;
          ctr2  <= 1'b1;
          busy  <= DONE_BUSY;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept) begin
        state      <= ST_LOAD;
        opc        <= ctr1;
        dst        <= radd1;
        src        <= radd2;
        imm_q      <= imm;
        rf_raddr_a <= radd2;
        rf_raddr_b <= radd1;
        err        <= !opc_legal(ctr1);
        busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mve_unit.sv
// Directed self-checking bench: one LAT=3 and one LAT=0 instance, each with its own
// behavioural register file; traces are sampled on falling edges, cycle k after edge k.
module tb_mve_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start3 = 1'b0;
  logic       start0 = 1'b0;
  logic [3:0] ctr1 = '0;
  logic [2:0] radd1 = '0;
  logic [2:0] radd2 = '0;
  logic [7:0] imm = '0;

  logic [2:0] ra3, rb3, wa3, ra0, rb0, wa0;
  logic [7:0] da3, db3, wd3, da0, db0, wd0;
  logic       we3, busy3, ctr23, err3, we0, busy0, ctr20, err0;

  logic [7:0] rf3 [0:7];
  logic [7:0] rf0 [0:7];
  logic       pre_we = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  logic       sel = 1'b0;
  logic       o_we, o_busy, o_ctr2, o_err;
  logic [2:0] o_wa, o_ra, o_rb;
  logic [7:0] o_wd;

  logic       tr_we [0:19];
  logic       tr_busy [0:19];
  logic       tr_ctr2 [0:19];
  logic       tr_err [0:19];
  logic [2:0] tr_wa [0:19];
  logic [2:0] tr_ra [0:19];
  logic [2:0] tr_rb [0:19];
  logic [7:0] tr_wd [0:19];

  int total = 0;
  int bad = 0;

`ifdef MVE_BACK2BACK_EN
  localparam logic DONE_BUSY = 1'b0;
  localparam int   B2B_WE = 11;
  localparam int   B2B_DONE = 12;
`else
  localparam logic DONE_BUSY = 1'b1;
  localparam int   B2B_WE = 12;
  localparam int   B2B_DONE = 13;
`endif

  always #5 clk = ~clk;

  mve_unit #(.DW(8), .AW(3), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ctr1(ctr1), .radd1(radd1), .radd2(radd2),
    .imm(imm), .rf_raddr_a(ra3), .rf_rdata_a(da3), .rf_raddr_b(rb3), .rf_rdata_b(db3),
    .rf_we(we3), .rf_waddr(wa3), .rf_wdata(wd3), .busy(busy3), .ctr2(ctr23), .err(err3)
  );

  mve_unit #(.DW(8), .AW(3), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ctr1(ctr1), .radd1(radd1), .radd2(radd2),
    .imm(imm), .rf_raddr_a(ra0), .rf_rdata_a(da0), .rf_raddr_b(rb0), .rf_rdata_b(db0),
    .rf_we(we0), .rf_waddr(wa0), .rf_wdata(wd0), .busy(busy0), .ctr2(ctr20), .err(err0)
  );

  assign da3 = rf3[ra3];
  assign db3 = rf3[rb3];
  assign da0 = rf0[ra0];
  assign db0 = rf0[rb0];

  always @(posedge clk) begin
    if (pre_we) begin
      rf3[pre_addr] <= pre_data;
      rf0[pre_addr] <= pre_data;
    end else begin
      if (we3) rf3[wa3] <= wd3;
      if (we0) rf0[wa0] <= wd0;
    end
  end

  assign o_we   = sel ? we0   : we3;
  assign o_busy = sel ? busy0 : busy3;
  assign o_ctr2 = sel ? ctr20 : ctr23;
  assign o_err  = sel ? err0  : err3;
  assign o_wa   = sel ? wa0   : wa3;
  assign o_wd   = sel ? wd0   : wd3;
  assign o_ra   = sel ? ra0   : ra3;
  assign o_rb   = sel ? rb0   : rb3;

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // start is seen at edges k where k < hold or k == pulse; edge 0 is the accepting edge
  task automatic run_op(input logic use0, input logic [3:0] opc, input logic [2:0] dst,
                        input logic [2:0] src, input logic [7:0] im, input int hold,
                        input int pulse, input int ncyc);
    logic s;
    @(negedge clk);
    sel = use0; ctr1 = opc; radd1 = dst; radd2 = src; imm = im;
    if (use0) start0 = 1'b1; else start3 = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      tr_we[k] = o_we; tr_busy[k] = o_busy; tr_ctr2[k] = o_ctr2; tr_err[k] = o_err;
      tr_wa[k] = o_wa; tr_wd[k] = o_wd; tr_ra[k] = o_ra; tr_rb[k] = o_rb;
      s = (k < hold) || (k == pulse);
      if (use0) start0 = s; else start3 = s;
    end
    start0 = 1'b0; start3 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({we3, busy3, ctr23, err3, ra3, rb3, wa3, wd3} !== 22'd0) begin
      bad++;
      $display("FAIL reset_dut3 got=%h want=0", {we3, busy3, ctr23, err3, ra3, rb3, wa3, wd3});
    end
    total++;
    if ({we0, busy0, ctr20, err0, ra0, rb0, wa0, wd0} !== 22'd0) begin
      bad++;
      $display("FAIL reset_dut0 got=%h want=0", {we0, busy0, ctr20, err0, ra0, rb0, wa0, wd0});
    end
    rst_n = 1'b1;
    $display("reset: outputs checked after 2 reset edges");
  endtask

  task automatic test_mov;
    preload(3'd2, 8'h5A);
    preload(3'd5, 8'h00);
    run_op(1'b0, 4'b1011, 3'd5, 3'd2, 8'h00, 1, -1, 10);
    total++;
    if (tr_ra[1] !== 3'd2 || tr_rb[1] !== 3'd5) begin
      bad++;
      $display("FAIL mov_raddr got=%0d/%0d want=2/5", tr_ra[1], tr_rb[1]);
    end
    for (int k = 1; k <= 10; k++) begin
      total++;
      if (tr_we[k] !== (k == 5) || tr_ctr2[k] !== (k == 6)) begin
        bad++;
        $display("FAIL mov_timing c%0d got we=%b ctr2=%b want we=%b ctr2=%b",
                 k, tr_we[k], tr_ctr2[k], k == 5, k == 6);
      end
    end
    total++;
    if (tr_wa[5] !== 3'd5 || tr_wd[5] !== 8'h5A) begin
      bad++;
      $display("FAIL mov_write got=%0d/%h want=5/5a", tr_wa[5], tr_wd[5]);
    end
    total++;
    if (tr_busy[1] !== 1'b1 || tr_busy[5] !== 1'b1 || tr_busy[6] !== DONE_BUSY || tr_busy[7] !== 1'b0) begin
      bad++;
      $display("FAIL mov_busy got=%b%b%b%b want=11%b0", tr_busy[1], tr_busy[5], tr_busy[6], tr_busy[7], DONE_BUSY);
    end
    total++;
    if (rf3[5] !== 8'h5A) begin
      bad++;
      $display("FAIL mov_reg got=%h want=5a", rf3[5]);
    end
    $display("mov: R5<=R2 LAT=3 write=%0d/%h", tr_wa[5], tr_wd[5]);
  endtask

  task automatic test_mvi;
    preload(3'd7, 8'h00);
    run_op(1'b1, 4'b1100, 3'd7, 3'd0, 8'hC3, 1, -1, 6);
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (tr_we[k] !== (k == 2) || tr_ctr2[k] !== (k == 3)) begin
        bad++;
        $display("FAIL mvi_timing c%0d got we=%b ctr2=%b want we=%b ctr2=%b",
                 k, tr_we[k], tr_ctr2[k], k == 2, k == 3);
      end
    end
    total++;
    if (tr_wa[2] !== 3'd7 || tr_wd[2] !== 8'hC3 || rf0[7] !== 8'hC3) begin
      bad++;
      $display("FAIL mvi_write got=%0d/%h reg=%h want=7/c3 reg=c3", tr_wa[2], tr_wd[2], rf0[7]);
    end
    $display("mvi: R7<=c3 LAT=0 write=%0d/%h", tr_wa[2], tr_wd[2]);
  endtask

  task automatic test_swp;
    preload(3'd1, 8'h11);
    preload(3'd4, 8'h44);
    run_op(1'b0, 4'b1101, 3'd1, 3'd4, 8'h00, 1, -1, 10);
    for (int k = 1; k <= 10; k++) begin
      total++;
      if (tr_we[k] !== (k == 5 || k == 6) || tr_ctr2[k] !== (k == 7)) begin
        bad++;
        $display("FAIL swp_timing c%0d got we=%b ctr2=%b", k, tr_we[k], tr_ctr2[k]);
      end
    end
    total++;
    if (tr_wa[5] !== 3'd1 || tr_wd[5] !== 8'h44 || tr_wa[6] !== 3'd4 || tr_wd[6] !== 8'h11) begin
      bad++;
      $display("FAIL swp_write got=%0d/%h %0d/%h want=1/44 4/11", tr_wa[5], tr_wd[5], tr_wa[6], tr_wd[6]);
    end
    total++;
    if (rf3[1] !== 8'h44 || rf3[4] !== 8'h11) begin
      bad++;
      $display("FAIL swp_regs got=%h/%h want=44/11", rf3[1], rf3[4]);
    end
    $display("swp: R1<->R4 -> %h/%h", rf3[1], rf3[4]);
  endtask

  task automatic test_swp_same;
    preload(3'd3, 8'h33);
    run_op(1'b0, 4'b1101, 3'd3, 3'd3, 8'h00, 1, -1, 10);
    total++;
    if (tr_we[5] !== 1'b1 || tr_we[6] !== 1'b1 || tr_ctr2[7] !== 1'b1) begin
      bad++;
      $display("FAIL swp_same_timing got=%b%b%b want=111", tr_we[5], tr_we[6], tr_ctr2[7]);
    end
    total++;
    if (tr_wa[5] !== 3'd3 || tr_wd[5] !== 8'h33 || tr_wa[6] !== 3'd3 || tr_wd[6] !== 8'h33) begin
      bad++;
      $display("FAIL swp_same_write got=%0d/%h %0d/%h want=3/33 3/33", tr_wa[5], tr_wd[5], tr_wa[6], tr_wd[6]);
    end
    total++;
    if (rf3[3] !== 8'h33) begin
      bad++;
      $display("FAIL swp_same_reg got=%h want=33", rf3[3]);
    end
    $display("swp_same: R3 -> %h", rf3[3]);
  endtask

  task automatic test_illegal;
    run_op(1'b0, 4'b0000, 3'd5, 3'd2, 8'h00, 1, -1, 6);
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (tr_err[k] !== (k == 1) || tr_we[k] !== 1'b0 || tr_ctr2[k] !== 1'b0 || tr_busy[k] !== (k == 1)) begin
        bad++;
        $display("FAIL illegal c%0d got err=%b we=%b ctr2=%b busy=%b", k, tr_err[k], tr_we[k], tr_ctr2[k], tr_busy[k]);
      end
    end
    $display("illegal: opcode 0000 err=%b", tr_err[1]);
  endtask

  task automatic test_wait_ignore;
    preload(3'd5, 8'h00);
    run_op(1'b0, 4'b1011, 3'd5, 3'd2, 8'h00, 1, 3, 12);
    for (int k = 1; k <= 12; k++) begin
      total++;
      if (tr_we[k] !== (k == 5) || tr_ctr2[k] !== (k == 6) || tr_busy[k] !== ((k <= 5) || (k == 6 && DONE_BUSY))) begin
        bad++;
        $display("FAIL wait_ignore c%0d got we=%b ctr2=%b busy=%b", k, tr_we[k], tr_ctr2[k], tr_busy[k]);
      end
    end
    total++;
    if (rf3[5] !== 8'h5A) begin
      bad++;
      $display("FAIL wait_ignore_reg got=%h want=5a", rf3[5]);
    end
    $display("wait_ignore: start pulse in WAIT dropped");
  endtask

  task automatic test_back_to_back;
    preload(3'd5, 8'h00);
    run_op(1'b0, 4'b1011, 3'd5, 3'd2, 8'h00, 8, -1, 16);
    for (int k = 1; k <= 16; k++) begin
      total++;
      if (tr_we[k] !== (k == 5 || k == B2B_WE) || tr_ctr2[k] !== (k == 6 || k == B2B_DONE)) begin
        bad++;
        $display("FAIL b2b_timing c%0d got we=%b ctr2=%b want we=%b ctr2=%b", k, tr_we[k], tr_ctr2[k],
                 (k == 5 || k == B2B_WE), (k == 6 || k == B2B_DONE));
      end
    end
    $display("back_to_back: second write at cycle %0d", B2B_WE);
  endtask

  task automatic test_reset_midop;
    preload(3'd1, 8'h11);
    preload(3'd4, 8'h44);
    @(negedge clk);
    sel = 1'b0; ctr1 = 4'b1101; radd1 = 3'd1; radd2 = 3'd4;
    start3 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (k == 3) rst_n = 1'b0;
      if (k == 5) rst_n = 1'b1;
      if (k == 4) begin
        total++;
        if ({we3, busy3, ctr23, err3, ra3, rb3, wa3, wd3} !== 22'd0) begin
          bad++;
          $display("FAIL reset_midop_outputs got=%h want=0", {we3, busy3, ctr23, err3, ra3, rb3, wa3, wd3});
        end
      end
      if (k >= 4) begin
        total++;
        if (we3 !== 1'b0 || ctr23 !== 1'b0 || busy3 !== 1'b0) begin
          bad++;
          $display("FAIL reset_midop_quiet c%0d got we=%b ctr2=%b busy=%b want 0", k, we3, ctr23, busy3);
        end
      end
    end
    total++;
    if (rf3[1] !== 8'h11 || rf3[4] !== 8'h44) begin
      bad++;
      $display("FAIL reset_midop_regs got=%h/%h want=11/44", rf3[1], rf3[4]);
    end
    $display("reset_midop: SWP aborted in WAIT");
  endtask

  initial begin
    test_reset();
    test_mov();
    test_mvi();
    test_swp();
    test_swp_same();
    test_illegal();
    test_wait_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mve_unit.md
# mve_unit

Parametrised register-move execution unit for the basic processor datapath, successor to the fixed 8-bit move block. On a start strobe it decodes a 4-bit opcode and performs MOV (reg→reg), MVI (immediate→reg) or SWP (reg↔reg) against an external register file through two read ports and one write port. It holds the operation for a programmable number of stall cycles, then reports completion on `ctr2`. It sits between the instruction decoder and the register file.

## Interface
Parameters:
- `DW`, 8, data width
- `AW`, 3, register address width
- `LAT`, 3, stall cycles between operand capture and first write; 0 is legal

Ports:
- `clk` in 1, sole clock; all logic on rising edge
- `rst_n` in 1, synchronous, active-low reset
- `start` in 1, request strobe; sampled only when accepting
- `ctr1` in 4, opcode: MOV=4'b1011, MVI=4'b1100, SWP=4'b1101; others illegal
- `radd1` in AW, destination register
- `radd2` in AW, source register
- `imm` in DW, immediate for MVI
- `rf_raddr_a` out AW, read port A address (source)
- `rf_rdata_a` in DW, read port A data, combinational from regfile
- `rf_raddr_b` out AW, read port B address (destination)
- `rf_rdata_b` in DW, read port B data
- `rf_we` out 1, write enable
- `rf_waddr` out AW, write address
- `rf_wdata` out DW, write data
- `busy` out 1, operation in progress
- `ctr2` out 1, one-cycle done pulse
- `err` out 1, one-cycle illegal-opcode pulse

## Operation
- FSM states: IDLE, LOAD, WAIT, WR1, WR2, DONE.
- IDLE: `start`=1 latches `ctr1`, `radd1`, `radd2`, `imm`; goes to LOAD.
- LOAD: `rf_raddr_a`=latched src, `rf_raddr_b`=latched dst; captures `rf_rdata_a`/`rf_rdata_b` into holding regs. Illegal opcode: pulse `err`, no capture, return to IDLE, no `ctr2`.
- WAIT: down-counter loaded with LAT on LOAD exit, decremented each cycle; exits to WR1 when zero. LAT=0 goes LOAD→WR1 directly.
- WR1: `rf_we`=1, `rf_waddr`=dst; `rf_wdata`=captured src (MOV, SWP) or latched imm (MVI). MOV/MVI→DONE, SWP→WR2.
- WR2 (SWP only): `rf_we`=1, `rf_waddr`=src, `rf_wdata`=captured old dst.
- DONE: `ctr2`=1 for one cycle; returns to IDLE.
- SWP with src==dst: both writes occur with the same value; the register is unchanged.
- `start` outside accepting states is ignored, with no queuing.
- Read addresses hold their last value outside LOAD. `rf_waddr`/`rf_wdata` are don't-care when `rf_we`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, `rf_we`=0, `ctr2`=0, `err`=0, `busy`=0, `rf_raddr_a`/`rf_raddr_b`/`rf_waddr`/`rf_wdata`=0, counter=0.
- Reset mid-operation aborts at the next edge. No pending write is issued after reset.
- `start` accepted at edge 0: LOAD in cycle 1, WAIT in cycles 2..LAT+1, WR1 in cycle LAT+2.
  - MOV/MVI: `ctr2` in cycle LAT+3.
  - SWP: WR2 in cycle LAT+3, `ctr2` in cycle LAT+4.
- Illegal opcode: `err` in cycle 1, IDLE in cycle 2.
- `busy`=1 in every state except IDLE; it is a registered (Moore) output.
- Counter width is max(1, $clog2(LAT+1)); no wrap-around is possible.

## Configuration
- `MVE_BACK2BACK_EN` defined:
  - DONE also accepts `start`, going directly to LOAD while still pulsing `ctr2`.
  - `busy`=0 in DONE.
  - Back-to-back MOV throughput is LAT+3 cycles.
- Not defined:
  - DONE always returns to IDLE and `start` in DONE is ignored.
  - Back-to-back throughput is LAT+4 cycles.

## Structure
- `mve_pkg`: opcode localparams (OPC_MOV, OPC_MVI, OPC_SWP) and the state enum typedef.
- Sub-module `mve_delay_ctr`: loadable down-counter, parameter LAT, ports load, zero flag.
- Top module `mve_unit` holds the FSM, latches and output registers.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles mid-SWP (WR1 pending) -> no `rf_we` after reset, all outputs 0, IDLE.
- MOV, LAT=3: R2=0x5A, start `ctr1`=1011, `radd1`=5, `radd2`=2 -> `rf_we` at cycle 5 with waddr 5 / wdata 0x5A, `ctr2` at cycle 6.
- MVI, LAT=0: `imm`=0xC3, `radd1`=7 -> write R7=0xC3 at cycle 2, `ctr2` at cycle 3.
- SWP, LAT=3: R1=0x11, R4=0x44, `radd1`=1, `radd2`=4 -> cycle 5 writes R1=0x44, cycle 6 writes R4=0x11, `ctr2` at cycle 7. Repeat with src=dst=3 -> R3 unchanged.
- Illegal `ctr1`=4'b0000 -> `err` at cycle 1, no `rf_we`, no `ctr2`. A `start` pulsed during WAIT is ignored.
- Back-to-back: `start` held high across two MOVs -> second accepted in DONE (cycle LAT+3) with macro, in IDLE (cycle LAT+4) without.
